mips_boot_memory: RTL and testbench
===================================

# mips_boot_memory

Unified instruction/data word memory sitting directly upstream of the `mips` core: drives its `instr_in` and `data_in` inputs, serves its `instr_addr`, `data_addr`, `data_out` and `data_rd_wr` outputs, and holds the core in reset until a program image has been streamed in. After reset, a valid/ready load port fills the memory from word 0. The block then releases `core_reset` and serves the core with one-cycle synchronous reads and writes.

## Interface
- `depth_words`, 1024: memory depth in 32-bit words; power of two, ≥ 4.
- `base_addr`, 32'h0000_0000: byte address mapped to word 0; word aligned.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; one clock; polarity/synchronicity fixed.
- `load_valid`  in  1  load beat present.
- `load_data`  in  32  program word.
- `load_last`  in  1  final beat of image.
- `load_ready`  out  1  block accepts a beat this cycle.
- `core_reset`  out  1  drives core `reset`.
- `instr_addr`  in  32  from core, byte address.
- `instr_out`  out  32  to core `instr_in`.
- `data_addr`  in  32  from core, byte address.
- `data_wdata`  in  32  from core `data_out`.
- `data_rd_wr`  in  1  from core; 1 = read, 0 = write.
- `data_rdata`  out  32  to core `data_in`.
- `loaded_words`  out  32  number of words accepted in the last load.
- `load_error`  out  1  sticky: image exceeded `depth_words`.
- `access_fault`  out  1  sticky: core access misaligned or out of range.

## Operation
- FSM states: LOAD, RUN. A `reset` edge forces LOAD, load pointer = 0, `loaded_words` = 0, and clears `load_error` and `access_fault`. Memory contents are never cleared.
- LOAD:
  - `load_ready` = 1; beat accepted when `load_valid & load_ready`.
  - An accepted beat writes `mem[ptr] <= load_data`, then `ptr++` and `loaded_words++`.
  - Accepted beat with `load_last` = 1 → RUN.
  - Accepted beat at `ptr == depth_words-1` with `load_last` = 0 → RUN and `load_error` <= 1. Further beats are never accepted.
- RUN:
  - `load_ready` = 0; `load_valid` ignored.
  - Only `reset` leaves RUN.
- `core_reset` = `reset | (state != RUN)`.
- Address decode, both ports: `idx = (addr - base_addr) >> 2`. An access is valid iff `addr[1:0] == 0` and `idx < depth_words`.
- Instruction port, every cycle in RUN: `instr_out <= valid ? mem[idx] : 0`.
- Data port, every cycle in RUN:
  - `data_rd_wr` = 1: `data_rdata <= valid ? mem[idx] : 0`.
  - `data_rd_wr` = 0 and valid: `mem[idx] <= data_wdata`; `data_rdata` holds.
  - Invalid address on either port: `access_fault` <= 1; writes are dropped.
- In LOAD, both read outputs are driven 0, core writes are ignored, and no fault is flagged.
- Repeated identical writes (the core holds `data_rd_wr` = 0 for two cycles) are harmless.

## Timing
- Reset values, on the cycle after a `reset` edge:
  - `instr_out` = 0, `data_rdata` = 0, `loaded_words` = 0, `load_error` = 0, `access_fault` = 0.
  - `load_ready` = 1, `core_reset` = 1.
- While `reset` is high, `load_ready` = 0.
- Load throughput: 1 word/cycle.
- RUN is entered at the edge that accepts the last beat. `core_reset` falls in the following cycle.
- Read latency: 1 cycle. An address presented in cycle N yields data in cycle N+1, stable until the next edge. This suffices because the core holds addresses ≥ 2 cycles per stage.
- Write latency: the write lands at the edge ending the cycle in which it is presented. A read of the same word becomes visible one cycle after the next read request.
- Same-cycle instruction read and data write to the same word: `instr_out` returns the old value (read-before-write).
- Reset mid-load: the load aborts and the pointer restarts at 0. Previously written words persist until overwritten.
- Storage: a single write port shared by load and data writes, with two read ports.

## Test plan
- `base_addr` = 0. Stream 4 words 0x24080005, 0x24090003, 0x01095021, 0x00000000 with `load_last` on beat 4. Required: `core_reset` low exactly 1 cycle after beat 4, `loaded_words` = 4, and `instr_addr` = 8 returns 0x01095021 one cycle later.
- RUN: write 0xDEADBEEF to 0x40, then read 0x40. Required: `data_rdata` = 0xDEADBEEF one cycle after the read request. An instruction read of 0x40 issued in the same cycle as the write returns the prior value.
- `depth_words` = 8: stream 10 beats with no `load_last`. Required: 8 accepted, `load_ready` low from beat 9, `load_error` = 1, RUN entered.
- RUN: read 0x42, then read `base_addr + 4*depth_words`. Required: `data_rdata` = 0 for both, `access_fault` = 1, memory unchanged.
- Assert `reset` after 3 of 6 beats, then reload 2 words ending in `load_last`. Required: `loaded_words` = 2, word 2 still holds its first-load value, `core_reset` releases.
- RUN: pulse `load_valid` with data. Required: `load_ready` = 0 and memory unchanged.

Source files
------------

// File: rtl/mips_boot_memory.sv
// Boot/unified word memory for the mips core: streams a program image in over a
// valid/ready port, then releases core_reset and serves one-cycle instruction/data accesses.
module mips_boot_memory #(
    parameter int          depth_words = 1024,
    parameter logic [31:0] base_addr   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        core_reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_rd_wr,
    output logic [31:0] data_rdata,
    output logic [31:0] loaded_words,
    output logic        load_error,
    output logic        access_fault
);
    localparam int AW = $clog2(depth_words);
    localparam logic [AW-1:0] LAST_IDX = AW'(depth_words - 1);

    typedef enum logic {LOAD, RUN} state_t;
    state_t state_reg, state_next;

    logic [31:0]   mem [depth_words];
    logic [AW-1:0] ptr_reg;
    logic [31:0]   loaded_words_reg;
    logic          load_error_reg, access_fault_reg;
    logic [31:0]   instr_q_reg, data_q_reg;
    logic          instr_ok_reg, data_ok_reg;

    logic          run, load_fire;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;

    // Port 0 = instruction fetch, port 1 = data access; identical decode for both.
    logic [31:0]   port_addr [2];
    logic [AW-1:0] port_idx  [2];
    logic          port_ok   [2];

    assign port_addr[0] = instr_addr;
    assign port_addr[1] = data_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            logic [31:0] off;
            assign off          = port_addr[gi] - base_addr;
            assign port_idx[gi] = off[AW+1:2];
            // Addresses below base_addr wrap to huge offsets and fail the range test.
            assign port_ok[gi]  = (off[1:0] == 2'b00) && ((off >> 2) < 32'(depth_words));
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= LOAD;
        else       state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (state_reg == LOAD && load_fire && (load_last || ptr_reg == LAST_IDX))
            state_next = RUN;
    end

    // FSM: outputs
    always_comb begin
        run        = (state_reg == RUN);
        load_ready = (state_reg == LOAD) && !reset;
        core_reset = reset || (state_reg != RUN);
    end

    assign load_fire = load_valid && load_ready;

    // Single write port: the loader owns it in LOAD, the core's data port in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr_reg;
        wr_data = load_data;
        if (load_fire) begin
            wr_en = 1'b1;
        end else if (run && !reset && !data_rd_wr && port_ok[1]) begin
            wr_en   = 1'b1;
            wr_idx  = port_idx[1];
            wr_data = data_wdata;
        end
    end

    // Storage with two registered read ports; reads see the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
        instr_q_reg <= mem[port_idx[0]];
        if (data_rd_wr) data_q_reg <= mem[port_idx[1]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg          <= '0;
            loaded_words_reg <= '0;
            load_error_reg   <= 1'b0;
            access_fault_reg <= 1'b0;
            instr_ok_reg     <= 1'b0;
            data_ok_reg      <= 1'b0;
        end else begin
            if (load_fire) begin
                ptr_reg          <= ptr_reg + 1'b1;
                loaded_words_reg <= loaded_words_reg + 32'd1;
                if (ptr_reg == LAST_IDX && !load_last) load_error_reg <= 1'b1;
            end
            instr_ok_reg <= run && port_ok[0];
            // A data write leaves the previous read result on data_rdata.
            if (!run)            data_ok_reg <= 1'b0;
            else if (data_rd_wr) data_ok_reg <= port_ok[1];
            if (run && !(port_ok[0] && port_ok[1])) access_fault_reg <= 1'b1;
        end
    end

    assign instr_out    = instr_ok_reg ? instr_q_reg : 32'h0;
    assign data_rdata   = data_ok_reg  ? data_q_reg  : 32'h0;
    assign loaded_words = loaded_words_reg;
    assign load_error   = load_error_reg;
    assign access_fault = access_fault_reg;
endmodule

// File: tb/tb_mips_boot_memory.sv
// Directed bench for mips_boot_memory: a default-depth instance for load/run/reset
// behaviour and a depth-8 instance for image overflow and range faults.
module tb_mips_boot_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: depth 1024
    logic        reset_a, load_valid_a, load_last_a, data_rd_wr_a;
    logic [31:0] load_data_a, instr_addr_a, data_addr_a, data_wdata_a;
    logic        load_ready_a, core_reset_a, load_error_a, access_fault_a;
    logic [31:0] instr_out_a, data_rdata_a, loaded_words_a;

    // Instance B: depth 8
    logic        reset_b, load_valid_b, load_last_b, data_rd_wr_b;
    logic [31:0] load_data_b, instr_addr_b, data_addr_b, data_wdata_b;
    logic        load_ready_b, core_reset_b, load_error_b, access_fault_b;
    logic [31:0] instr_out_b, data_rdata_b, loaded_words_b;

    mips_boot_memory dut_a (
        .clk(clk), .reset(reset_a),
        .load_valid(load_valid_a), .load_data(load_data_a), .load_last(load_last_a),
        .load_ready(load_ready_a), .core_reset(core_reset_a),
        .instr_addr(instr_addr_a), .instr_out(instr_out_a),
        .data_addr(data_addr_a), .data_wdata(data_wdata_a), .data_rd_wr(data_rd_wr_a),
        .data_rdata(data_rdata_a), .loaded_words(loaded_words_a),
        .load_error(load_error_a), .access_fault(access_fault_a)
    );

    mips_boot_memory #(.depth_words(8), .base_addr(32'h0)) dut_b (
        .clk(clk), .reset(reset_b),
        .load_valid(load_valid_b), .load_data(load_data_b), .load_last(load_last_b),
        .load_ready(load_ready_b), .core_reset(core_reset_b),
        .instr_addr(instr_addr_b), .instr_out(instr_out_b),
        .data_addr(data_addr_b), .data_wdata(data_wdata_b), .data_rd_wr(data_rd_wr_b),
        .data_rdata(data_rdata_b), .loaded_words(loaded_words_b),
        .load_error(load_error_b), .access_fault(access_fault_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %-22s observed=%h expected=%h", tag, observed, expected);
    endtask

    logic [31:0] image [4] = '{32'h24080005, 32'h24090003, 32'h01095021, 32'h00000000};

    initial begin
        reset_a = 1'b1; load_valid_a = 1'b0; load_last_a = 1'b0; load_data_a = '0;
        instr_addr_a = '0; data_addr_a = '0; data_wdata_a = '0; data_rd_wr_a = 1'b1;
        reset_b = 1'b1; load_valid_b = 1'b0; load_last_b = 1'b0; load_data_b = '0;
        instr_addr_b = '0; data_addr_b = '0; data_wdata_b = '0; data_rd_wr_b = 1'b1;

        // Reset state
        step();
        check("ready_in_reset", load_ready_a, 1'b0);
        check("core_reset_in_reset", core_reset_a, 1'b1);
        reset_a = 1'b0;
        #1;
        check("rst_instr_out", instr_out_a, 32'h0);
        check("rst_data_rdata", data_rdata_a, 32'h0);
        check("rst_loaded_words", loaded_words_a, 32'd0);
        check("rst_load_error", load_error_a, 1'b0);
        check("rst_access_fault", access_fault_a, 1'b0);
        check("rst_load_ready", load_ready_a, 1'b1);
        check("rst_core_reset", core_reset_a, 1'b1);

        // Stream the 4-word image, last on beat 4
        for (int i = 0; i < 4; i++) begin
            load_valid_a = 1'b1; load_data_a = image[i]; load_last_a = (i == 3);
            step();
            if (i == 2) check("core_reset_beat3", core_reset_a, 1'b1);
        end
        load_valid_a = 1'b0; load_last_a = 1'b0;
        check("core_reset_after_last", core_reset_a, 1'b0);
        check("loaded_words_4", loaded_words_a, 32'd4);
        check("ready_in_run", load_ready_a, 1'b0);
        check("instr_out_load_zero", instr_out_a, 32'h0);
        instr_addr_a = 32'h8;
        step();
        check("instr_read_8", instr_out_a, 32'h01095021);
        check("data_read_0", data_rdata_a, 32'h24080005);

        // Writes to 0x40; read-before-write on the instruction port
        data_addr_a = 32'h40; data_wdata_a = 32'h11111111; data_rd_wr_a = 1'b0;
        step();
        check("rdata_hold_on_write", data_rdata_a, 32'h24080005);
        data_wdata_a = 32'hDEADBEEF; instr_addr_a = 32'h40;
        step();
        check("instr_rbw_old_value", instr_out_a, 32'h11111111);
        data_rd_wr_a = 1'b1;
        step();
        check("data_read_40", data_rdata_a, 32'hDEADBEEF);
        check("instr_read_40", instr_out_a, 32'hDEADBEEF);
        check("no_fault_valid", access_fault_a, 1'b0);

        // Invalid accesses
        data_addr_a = 32'h42;
        step();
        check("misaligned_rdata", data_rdata_a, 32'h0);
        check("misaligned_fault", access_fault_a, 1'b1);
        data_addr_a = 32'h1000;
        step();
        check("out_of_range_rdata", data_rdata_a, 32'h0);
        data_addr_a = 32'h42; data_wdata_a = 32'hBADBAD00; data_rd_wr_a = 1'b0;
        step();
        data_addr_a = 32'h40; data_rd_wr_a = 1'b1;
        step();
        check("bad_write_dropped", data_rdata_a, 32'hDEADBEEF);

        // Reset mid-load, then a 2-word reload
        instr_addr_a = 32'h8; data_addr_a = 32'h0;
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid_a = 1'b1; load_data_a = 32'hA0 + 32'(i);
            step();
        end
        reset_a = 1'b1; load_data_a = 32'hA3;
        step();
        reset_a = 1'b0; load_valid_a = 1'b0;
        check("abort_loaded_words", loaded_words_a, 32'd0);
        check("abort_core_reset", core_reset_a, 1'b1);
        for (int i = 0; i < 2; i++) begin
            load_valid_a = 1'b1; load_data_a = 32'hB0 + 32'(i); load_last_a = (i == 1);
            step();
        end
        load_valid_a = 1'b0; load_last_a = 1'b0;
        check("reload_words_2", loaded_words_a, 32'd2);
        check("reload_core_reset", core_reset_a, 1'b0);
        check("reload_no_error", load_error_a, 1'b0);
        step();
        check("word2_persists", instr_out_a, 32'hA2);
        check("word0_reloaded", data_rdata_a, 32'hB0);

        // Load beat offered in RUN is ignored
        load_valid_a = 1'b1; load_data_a = 32'hFFFFFFFF;
        #1;
        check("run_ready_low", load_ready_a, 1'b0);
        step();
        load_valid_a = 1'b0;
        step();
        check("run_load_ignored_mem", instr_out_a, 32'hA2);
        check("run_load_ignored_cnt", loaded_words_a, 32'd2);

        // Depth-8 overflow: 10 beats, no load_last
        reset_b = 1'b0;
        #1;
        check("b_rst_ready", load_ready_b, 1'b1);
        for (int i = 0; i < 10; i++) begin
            load_valid_b = 1'b1; load_data_b = 32'h100 + 32'(i);
            #1;
            check($sformatf("b_ready_beat%0d", i + 1), load_ready_b, (i < 8) ? 32'd1 : 32'd0);
            step();
        end
        load_valid_b = 1'b0;
        check("b_loaded_words_8", loaded_words_b, 32'd8);
        check("b_load_error", load_error_b, 1'b1);
        check("b_core_reset_low", core_reset_b, 1'b0);
        instr_addr_b = 32'h1C; data_addr_b = 32'h4;
        step();
        check("b_instr_word7", instr_out_b, 32'h107);
        check("b_data_word1", data_rdata_b, 32'h101);
        check("b_no_fault", access_fault_b, 1'b0);
        data_addr_b = 32'h42;
        step();
        check("b_misaligned_rdata", data_rdata_b, 32'h0);
        check("b_fault", access_fault_b, 1'b1);
        data_addr_b = 32'h20;
        step();
        check("b_end_rdata", data_rdata_b, 32'h0);
        data_addr_b = 32'h0;
        step();
        check("b_word0_unchanged", data_rdata_b, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
